m_sort_loader: RTL

//  Upstream input stage of the 16-input odd-even merge sorting network.

---
 rtl/sorter_pkg.sv | 22 ++
 rtl/m_sort_loader.sv | 92 +++++++++
 2 files changed

// File: rtl/sorter_pkg.sv
// Shared definitions for the odd-even merge sorter: default key geometry,
// pad value and loader state encoding.
`ifndef SORTER_PKG_SV
`define SORTER_PKG_SV

// Bit range of slot k inside a packed frame of WIDTH-bit keys
`define SORTER_SLOT(k) [((k)+1)*WIDTH-1:(k)*WIDTH]

package sorter_pkg;

  localparam int SORT_WIDTH = 3;
  localparam int SORT_N     = 16;
  localparam logic [SORT_WIDTH-1:0] SORT_PAD_VAL = {SORT_WIDTH{1'b1}};

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } loader_state_t;

endpackage

`endif

// File: rtl/m_sort_loader.sv
// Input stage of the 16-input odd-even merge sorter: packs a valid/ready key
// stream into one N-slot frame, pads short frames, holds the frame until taken.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_FILL | accepting keys into slot[wr_idx]; in_ready=1, out_valid=0
//   ST_FULL | frame complete and held stable; in_ready=0, out_valid=1
module m_sort_loader
  import sorter_pkg::*;
#(
  parameter int               WIDTH   = SORT_WIDTH,
  parameter int               N       = SORT_N,
  parameter logic [WIDTH-1:0] PAD_VAL = {WIDTH{1'b1}},
  parameter int               CW      = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [CW-1:0]      out_count
);

  localparam int IW = $clog2(N);

  loader_state_t    state;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] slot [N];

  logic accept;
  logic final_key;

  // in_ready is only high in ST_FILL, so accept can never fire while FULL
  assign accept    = in_valid & in_ready;
  assign final_key = in_last | (wr_idx == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FILL;
      wr_idx    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      for (int j = 0; j < N; j++) begin
        slot[j] <= '0;
      end
    end else begin
      case (state)
        ST_FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            slot[wr_idx] <= in_data;
            if (final_key) begin
              // Fill every slot past the last real key so pads sort to the top
              for (int j = 0; j < N; j++) begin
                if (IW'(j) > wr_idx) begin
                  slot[j] <= PAD_VAL;
                end
              end
              out_count <= CW'(wr_idx) + CW'(1);
              wr_idx    <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= ST_FULL;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            state     <= ST_FILL;
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign out_data `SORTER_SLOT(k) = slot[k];
  end

endmodule
